// File: rtl/ram_ctrl_pkg.sv
// Shared constants and helpers for the RAM port arbiter.
// Defaults match the team's simple dual-port RAM.
package ram_ctrl_pkg;

  localparam int DEF_D_WIDTH = 16;
  localparam int DEF_A_WIDTH = 5;
  localparam int MAX_REQ     = 8;
  localparam int RD_LAT      = 2;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle: request handshake plus
// the shared read-response bus.
interface ram_port_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH
);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         req_write;
  logic [N_REQ*A_WIDTH-1:0] req_addr;
  logic [N_REQ*D_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]         resp_valid;
  logic [D_WIDTH-1:0]       resp_rdata;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts
// at the pointer, pointer moves past the winner.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt;
  logic          hit;

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    nxt = ptr;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        nxt    = IW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port and one registered read
// port of a dual-port RAM among N_REQ requesters.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int N_REQ   = 2
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  logic [N_REQ-1:0] wr_req;
  logic [N_REQ-1:0] rd_req;
  logic [N_REQ-1:0] wr_gnt;
  logic [N_REQ-1:0] rd_gnt;

  logic [A_WIDTH-1:0] wa;
  logic [D_WIDTH-1:0] wd;
  logic [A_WIDTH-1:0] ra;

  // One-hot read winners riding alongside the RAM read latency
  logic [RD_LAT-1:0][N_REQ-1:0] tag_q;

  assign wr_req = bus.req_valid & bus.req_write;
  assign rd_req = bus.req_valid & ~bus.req_write;

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  always_comb begin
    wa = '0;
    wd = '0;
    ra = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_gnt[i]) begin
        wa = bus.req_addr[i*A_WIDTH +: A_WIDTH];
        wd = bus.req_wdata[i*D_WIDTH +: D_WIDTH];
      end
      if (rd_gnt[i]) begin
        ra = bus.req_addr[i*A_WIDTH +: A_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable  <= 1'b0;
      address_write <= '0;
      data_write    <= '0;
      address_read  <= '0;
      tag_q         <= '0;
    end else begin
      write_enable <= |wr_gnt;
      if (|wr_gnt) begin
        address_write <= wa;
        data_write    <= wd;
      end
      if (|rd_gnt) begin
        address_read <= ra;
      end
      tag_q <= {tag_q[RD_LAT-2:0], rd_gnt};
    end
  end

  assign bus.req_ready  = wr_gnt | rd_gnt;
  assign bus.resp_valid = tag_q[RD_LAT-1];
  assign bus.resp_rdata = data_read;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a
// behavioural dual-port RAM beside the DUT.
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct packed {
    logic [NR-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0] address_write;
  logic [DW-1:0] data_write;
  logic          write_enable;
  logic [AW-1:0] address_read;
  logic [DW-1:0] data_read;

  logic [DW-1:0] mem [32];

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DW-1:0] pre [8];

  ram_port_arbiter_if #(
    .N_REQ(NR), .D_WIDTH(DW), .A_WIDTH(AW)
  ) dbus ();

  ram_port_arbiter #(
    .D_WIDTH(DW), .A_WIDTH(AW), .N_REQ(NR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (dbus.slave),
    .address_write (address_write),
    .data_write    (data_write),
    .write_enable  (write_enable),
    .address_read  (address_read),
    .data_read     (data_read)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    data_read = '0;
  end

  always @(posedge clk) begin
    if (write_enable) mem[address_write] <= data_write;
    data_read <= mem[address_read];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dbus.resp_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp",
            {14'd0, dbus.resp_valid, dbus.resp_rdata},
            32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp",
            {14'd0, dbus.resp_valid, dbus.resp_rdata},
            {14'd0, e.tag, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    dbus.req_valid[i]             = 1'b1;
    dbus.req_write[i]             = w;
    dbus.req_addr[i*AW +: AW]     = a;
    dbus.req_wdata[i*DW +: DW]    = d;
  endtask

  task automatic wait_acc(input int i);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (dbus.req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wr1(input int i, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    set_req(i, 1'b1, a, d);
    wait_acc(i);
    step();
    dbus.req_valid[i] = 1'b0;
  endtask

  task automatic rd1(input int i, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    exp_t e;
    set_req(i, 1'b0, a, '0);
    wait_acc(i);
    e.tag  = NR'(1) << i;
    e.data = d;
    sbq.push_back(e);
    step();
    dbus.req_valid[i] = 1'b0;
  endtask

  task automatic push(input logic [NR-1:0] t,
                      input logic [DW-1:0] d);
    exp_t e;
    e.tag  = t;
    e.data = d;
    sbq.push_back(e);
  endtask

  initial begin
    int c[2];
    pre = '{16'hC0C0, 16'hC0C1, 16'hC0C2, 16'hC0C3,
            16'hC0C4, 16'hC0C5, 16'hC0C6, 16'hC0C7};
    dbus.req_valid = '0;
    dbus.req_write = '0;
    dbus.req_addr  = '0;
    dbus.req_wdata = '0;

    // reset state
    #2;
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_aw", {27'd0, address_write}, 32'd0);
    chk("rst_dw", {16'd0, data_write}, 32'd0);
    chk("rst_ar", {27'd0, address_read}, 32'd0);
    chk("rst_rv", {30'd0, dbus.resp_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // reset mid-read
    set_req(0, 1'b0, 5'd9, '0);
    @(negedge clk);
    chk("midrd_ready", {30'd0, dbus.req_ready}, 32'd1);
    step();
    dbus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_we", {31'd0, write_enable}, 32'd0);
    chk("midrd_rv1", {30'd0, dbus.resp_valid}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrd_rv2", {30'd0, dbus.resp_valid}, 32'd0);
    step();

    // read pointer back at 0: req0 wins first
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd0, '0);
    @(negedge clk);
    chk("rdptr_r0", {30'd0, dbus.req_ready}, 32'd1);
    push(2'b01, 16'h0000);
    step();
    dbus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rdptr_r1", {30'd0, dbus.req_ready}, 32'd2);
    push(2'b10, 16'h0000);
    step();
    dbus.req_valid = '0;
    step();

    // write contention
    set_req(0, 1'b1, 5'd1, 16'h1111);
    set_req(1, 1'b1, 5'd2, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wc_ready", {30'd0, dbus.req_ready},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0)
        chk("wc_aw", {27'd0, address_write},
            (k % 2 == 1) ? 32'd1 : 32'd2);
      step();
    end
    dbus.req_valid = '0;
    @(negedge clk);
    chk("wc_we_last", {31'd0, write_enable}, 32'd1);
    chk("wc_dw_last", {16'd0, data_write}, 32'h2222);
    step();
    @(negedge clk);
    chk("wc_we_idle", {31'd0, write_enable}, 32'd0);
    step();
    rd1(0, 5'd1, 16'h1111);
    rd1(1, 5'd2, 16'h2222);

    // single write then read, exact latency
    wr1(0, 5'd3, 16'hBEEF);
    set_req(0, 1'b0, 5'd3, '0);
    @(negedge clk);
    chk("wr_rd_ready", {30'd0, dbus.req_ready}, 32'd1);
    push(2'b01, 16'hBEEF);
    step();
    dbus.req_valid = '0;
    @(negedge clk);
    chk("lat_t1", {30'd0, dbus.resp_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("lat_t2", {30'd0, dbus.resp_valid}, 32'd1);
    step();

    // concurrent write and read classes
    wr1(1, 5'd5, 16'h5555);
    set_req(0, 1'b1, 5'd4, 16'hAAAA);
    set_req(1, 1'b0, 5'd5, '0);
    @(negedge clk);
    chk("cc_ready", {30'd0, dbus.req_ready}, 32'd3);
    push(2'b10, 16'h5555);
    step();
    dbus.req_valid = '0;
    rd1(0, 5'd4, 16'hAAAA);

    // same-cycle hazard returns old data
    wr1(0, 5'd7, 16'h0001);
    set_req(0, 1'b1, 5'd7, 16'h0002);
    set_req(1, 1'b0, 5'd7, '0);
    @(negedge clk);
    chk("hz_ready", {30'd0, dbus.req_ready}, 32'd3);
    push(2'b10, 16'h0001);
    step();
    dbus.req_valid = '0;
    rd1(1, 5'd7, 16'h0002);

    // back-to-back alternating reads
    for (int a = 0; a < 8; a++) wr1(a % 2, AW'(a), pre[a]);
    c[0] = 0;
    c[1] = 0;
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd1, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_ready", {30'd0, dbus.req_ready},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2)
        chk("b2b_rv", {30'd0, dbus.resp_valid},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      for (int i = 0; i < 2; i++) begin
        if (dbus.req_valid[i] && dbus.req_ready[i]) begin
          push(NR'(1) << i, pre[2*c[i] + i]);
          c[i]++;
        end
      end
      step();
      for (int i = 0; i < 2; i++) begin
        if (c[i] >= 4) dbus.req_valid[i] = 1'b0;
        else dbus.req_addr[i*AW +: AW] = AW'(2*c[i] + i);
      end
    end

    // drain with a bound
    for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
    step();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
